// File: rtl/dispatch_unit.sv
// dispatch_unit
//
// Takes one renamed micro-op per cycle from rename over a valid/ready
// handshake and parks it in a single hold register. From the hold register
// it builds a complete reservation-station cell:
//   - operand values from the physical register file,
//   - producer tags from the busy table plus an internal tag table,
//   - same-cycle forwarding from the common data bus (CDB).
// The cell goes to the lowest free reservation-station slot, and the ROB
// tail entry is allocated in the same cycle. The unit stalls while the ROB
// is full or no slot is free. A mispredicted branch flushes the held uop.
//
// Optional build macro: DISPATCH_STATS_EN adds three saturating 32-bit
// performance counters (stall_rob_cnt, stall_rs_cnt, dispatch_cnt).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       handshake with rename
//   in_op, in_dest, in_src1, in_src2, in_src1_used, in_src2_used, in_imm
//                             renamed uop fields (in_dest == 0 means none)
//   busy_rd1/2_addr/_data     busy-table lookup for the held sources
//   phy_rf_rd1/2_addr/_data   register-file lookup for the held sources
//   busy_set_en/_addr         mark the destination busy on dispatch
//   rob_tail_ptr, rob_full    ROB allocation state
//   rob_incr_tail_ptr         allocate the ROB tail entry
//   res_st_free               per-slot free mask
//   res_st_wr_*               reservation-station cell write
//   res_st_retire_*           CDB broadcast (valid, ROB tag, value)
//   mispredicted_branch       flush
//   stall_rob_cnt, stall_rs_cnt, dispatch_cnt  (DISPATCH_STATS_EN only)

module dispatch_unit #(
  parameter int ROB_ADDR_W    = 2,
  parameter int PHY_RF_ADDR_W = 6,
  parameter int RES_ST_COUNT  = 4,
  parameter int RES_ST_ADDR_W = 2,
  parameter int DATA_W        = 32,
  parameter int OP_W          = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  // rename side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [PHY_RF_ADDR_W-1:0] in_dest,
  input  logic [PHY_RF_ADDR_W-1:0] in_src1,
  input  logic [PHY_RF_ADDR_W-1:0] in_src2,
  input  logic                     in_src1_used,
  input  logic                     in_src2_used,
  input  logic [DATA_W-1:0]        in_imm,
  // busy table
  output logic [PHY_RF_ADDR_W-1:0] busy_rd1_addr,
  output logic [PHY_RF_ADDR_W-1:0] busy_rd2_addr,
  input  logic                     busy_rd1_data,
  input  logic                     busy_rd2_data,
  output logic                     busy_set_en,
  output logic [PHY_RF_ADDR_W-1:0] busy_set_addr,
  // physical register file
  output logic [PHY_RF_ADDR_W-1:0] phy_rf_rd1_addr,
  output logic [PHY_RF_ADDR_W-1:0] phy_rf_rd2_addr,
  input  logic [DATA_W-1:0]        phy_rf_rd1_data,
  input  logic [DATA_W-1:0]        phy_rf_rd2_data,
  // ROB
  input  logic [ROB_ADDR_W-1:0]    rob_tail_ptr,
  input  logic                     rob_full,
  output logic                     rob_incr_tail_ptr,
  // reservation station
  input  logic [RES_ST_COUNT-1:0]  res_st_free,
  output logic                     res_st_wr_en,
  output logic [RES_ST_ADDR_W-1:0] res_st_wr_addr,
  output logic [ROB_ADDR_W-1:0]    res_st_wr_rob_addr,
  output logic [PHY_RF_ADDR_W-1:0] res_st_wr_dest,
  output logic [OP_W-1:0]          res_st_wr_op,
  output logic [ROB_ADDR_W:0]      res_st_wr_qj,
  output logic [ROB_ADDR_W:0]      res_st_wr_qk,
  output logic [DATA_W-1:0]        res_st_wr_vj,
  output logic [DATA_W-1:0]        res_st_wr_vk,
  output logic [DATA_W-1:0]        res_st_wr_a,
  // CDB
  input  logic                     res_st_retire_en,
  input  logic [ROB_ADDR_W-1:0]    res_st_retire_rob_addr,
  input  logic [DATA_W-1:0]        res_st_retire_value,
`ifdef DISPATCH_STATS_EN
  output logic [31:0]              stall_rob_cnt,
  output logic [31:0]              stall_rs_cnt,
  output logic [31:0]              dispatch_cnt,
`endif
  // flush
  input  logic                     mispredicted_branch
);

  localparam int TAG_W        = ROB_ADDR_W + 1;
  localparam int PHY_RF_COUNT = 1 << PHY_RF_ADDR_W;

  // ---------------------------------------------------------------------
  // Hold register
  // ---------------------------------------------------------------------
  logic                     hold_valid_q, hold_valid_d;
  logic [OP_W-1:0]          hold_op_q, hold_op_d;
  logic [PHY_RF_ADDR_W-1:0] hold_dest_q, hold_dest_d;
  logic [PHY_RF_ADDR_W-1:0] hold_src1_q, hold_src1_d;
  logic [PHY_RF_ADDR_W-1:0] hold_src2_q, hold_src2_d;
  logic                     hold_src1_used_q, hold_src1_used_d;
  logic                     hold_src2_used_q, hold_src2_used_d;
  logic [DATA_W-1:0]        hold_imm_q, hold_imm_d;

  logic dispatch;
  logic accept;

  // rst is folded in so nothing leaves the unit while reset is held, even
  // before the first reset edge has cleared the hold register.
  assign dispatch = !rst && hold_valid_q && !rob_full && (|res_st_free)
                    && !mispredicted_branch;
  assign in_ready = !rst && !mispredicted_branch && (!hold_valid_q || dispatch);
  assign accept   = in_valid && in_ready;

  always_comb begin
    hold_valid_d     = hold_valid_q;
    hold_op_d        = hold_op_q;
    hold_dest_d      = hold_dest_q;
    hold_src1_d      = hold_src1_q;
    hold_src2_d      = hold_src2_q;
    hold_src1_used_d = hold_src1_used_q;
    hold_src2_used_d = hold_src2_used_q;
    hold_imm_d       = hold_imm_q;
    if (accept) begin
      // Covers the dispatch-and-accept case: the new uop replaces the one
      // leaving at this edge.
      hold_valid_d     = 1'b1;
      hold_op_d        = in_op;
      hold_dest_d      = in_dest;
      hold_src1_d      = in_src1;
      hold_src2_d      = in_src2;
      hold_src1_used_d = in_src1_used;
      hold_src2_used_d = in_src2_used;
      hold_imm_d       = in_imm;
    end else if (dispatch || mispredicted_branch) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q     <= 1'b0;
      hold_op_q        <= '0;
      hold_dest_q      <= '0;
      hold_src1_q      <= '0;
      hold_src2_q      <= '0;
      hold_src1_used_q <= 1'b0;
      hold_src2_used_q <= 1'b0;
      hold_imm_q       <= '0;
    end else begin
      hold_valid_q     <= hold_valid_d;
      hold_op_q        <= hold_op_d;
      hold_dest_q      <= hold_dest_d;
      hold_src1_q      <= hold_src1_d;
      hold_src2_q      <= hold_src2_d;
      hold_src1_used_q <= hold_src1_used_d;
      hold_src2_used_q <= hold_src2_used_d;
      hold_imm_q       <= hold_imm_d;
    end
  end

  // ---------------------------------------------------------------------
  // Tag table: ROB entry of the most recent producer of each phys reg.
  // Read combinationally every cycle so a stalled uop keeps re-looking up.
  // ---------------------------------------------------------------------
  logic [ROB_ADDR_W-1:0] tag_q [PHY_RF_COUNT];

  for (genvar gi = 0; gi < PHY_RF_COUNT; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (rst) begin
        tag_q[gi] <= '0;
      end else if (dispatch && (hold_dest_q == PHY_RF_ADDR_W'(gi))
                   && (hold_dest_q != '0)) begin
        tag_q[gi] <= rob_tail_ptr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Operand resolution (index 0 -> j/src1, index 1 -> k/src2)
  // ---------------------------------------------------------------------
  logic [PHY_RF_ADDR_W-1:0] src_addr [2];
  logic                     src_used [2];
  logic                     src_busy [2];
  logic [DATA_W-1:0]        src_rf   [2];

  assign src_addr[0] = hold_src1_q;
  assign src_addr[1] = hold_src2_q;
  assign src_used[0] = hold_src1_used_q;
  assign src_used[1] = hold_src2_used_q;
  assign src_busy[0] = busy_rd1_data;
  assign src_busy[1] = busy_rd2_data;
  assign src_rf[0]   = phy_rf_rd1_data;
  assign src_rf[1]   = phy_rf_rd2_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic [ROB_ADDR_W-1:0] prod_tag;
    logic [TAG_W-1:0]      opnd_q;
    logic [DATA_W-1:0]     opnd_v;

    assign prod_tag = tag_q[src_addr[gi]];

    // Tags are stored off-by-one in the cell so that q == 0 means "ready".
    always_comb begin
      opnd_q = '0;
      opnd_v = '0;
      if (src_used[gi] && (src_addr[gi] != '0)) begin
        if (!src_busy[gi]) begin
          opnd_v = src_rf[gi];
        end else if (res_st_retire_en && (res_st_retire_rob_addr == prod_tag)) begin
          opnd_v = res_st_retire_value;
        end else begin
          opnd_q = TAG_W'(prod_tag) + TAG_W'(1);
        end
      end
    end
  end

  assign busy_rd1_addr   = hold_src1_q;
  assign busy_rd2_addr   = hold_src2_q;
  assign phy_rf_rd1_addr = hold_src1_q;
  assign phy_rf_rd2_addr = hold_src2_q;

  // ---------------------------------------------------------------------
  // Lowest free slot
  // ---------------------------------------------------------------------
  logic [RES_ST_ADDR_W-1:0] slot_sel;

  always_comb begin
    slot_sel = '0;
    for (int i = RES_ST_COUNT - 1; i >= 0; i--) begin
      if (res_st_free[i]) slot_sel = RES_ST_ADDR_W'(i);
    end
  end

  // ---------------------------------------------------------------------
  // Cell write; every field is zero unless a dispatch happens this cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    res_st_wr_en       = 1'b0;
    rob_incr_tail_ptr  = 1'b0;
    busy_set_en        = 1'b0;
    busy_set_addr      = '0;
    res_st_wr_addr     = '0;
    res_st_wr_rob_addr = '0;
    res_st_wr_dest     = '0;
    res_st_wr_op       = '0;
    res_st_wr_qj       = '0;
    res_st_wr_qk       = '0;
    res_st_wr_vj       = '0;
    res_st_wr_vk       = '0;
    res_st_wr_a        = '0;
    if (dispatch) begin
      res_st_wr_en       = 1'b1;
      rob_incr_tail_ptr  = 1'b1;
      busy_set_en        = (hold_dest_q != '0);
      busy_set_addr      = hold_dest_q;
      res_st_wr_addr     = slot_sel;
      res_st_wr_rob_addr = rob_tail_ptr;
      res_st_wr_dest     = hold_dest_q;
      res_st_wr_op       = hold_op_q;
      res_st_wr_qj       = g_opnd[0].opnd_q;
      res_st_wr_qk       = g_opnd[1].opnd_q;
      res_st_wr_vj       = g_opnd[0].opnd_v;
      res_st_wr_vk       = g_opnd[1].opnd_v;
      res_st_wr_a        = hold_imm_q;
    end
  end

`ifdef DISPATCH_STATS_EN
  // ---------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------
  logic [31:0] stall_rob_cnt_q, stall_rs_cnt_q, dispatch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_rob_cnt_q <= '0;
      stall_rs_cnt_q  <= '0;
      dispatch_cnt_q  <= '0;
    end else begin
      if (hold_valid_q && rob_full && (stall_rob_cnt_q != '1))
        stall_rob_cnt_q <= stall_rob_cnt_q + 32'd1;
      if (hold_valid_q && !rob_full && (res_st_free == '0) && (stall_rs_cnt_q != '1))
        stall_rs_cnt_q <= stall_rs_cnt_q + 32'd1;
      if (dispatch && (dispatch_cnt_q != '1))
        dispatch_cnt_q <= dispatch_cnt_q + 32'd1;
    end
  end

  assign stall_rob_cnt = stall_rob_cnt_q;
  assign stall_rs_cnt  = stall_rs_cnt_q;
  assign dispatch_cnt  = dispatch_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Self-checking bench for dispatch_unit: table of single-uop vectors plus
// hand-written stall / flush / reset sequences. Expected cells go into a
// scoreboard queue when the dispatch cycle is set up; a negedge monitor pops
// and compares whenever the DUT writes a cell.

module tb_dispatch_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_op;
  logic [5:0]  in_dest, in_src1, in_src2;
  logic        in_src1_used, in_src2_used;
  logic [31:0] in_imm;
  logic [5:0]  busy_rd1_addr, busy_rd2_addr;
  logic        busy_rd1_data, busy_rd2_data;
  logic [5:0]  phy_rf_rd1_addr, phy_rf_rd2_addr;
  logic [31:0] phy_rf_rd1_data, phy_rf_rd2_data;
  logic        busy_set_en;
  logic [5:0]  busy_set_addr;
  logic [1:0]  rob_tail_ptr;
  logic        rob_full;
  logic        rob_incr_tail_ptr;
  logic [3:0]  res_st_free;
  logic        res_st_wr_en;
  logic [1:0]  res_st_wr_addr;
  logic [1:0]  res_st_wr_rob_addr;
  logic [5:0]  res_st_wr_dest;
  logic [13:0] res_st_wr_op;
  logic [2:0]  res_st_wr_qj, res_st_wr_qk;
  logic [31:0] res_st_wr_vj, res_st_wr_vk, res_st_wr_a;
  logic        res_st_retire_en;
  logic [1:0]  res_st_retire_rob_addr;
  logic [31:0] res_st_retire_value;
  logic        mispredicted_branch;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stall_rob_cnt, stall_rs_cnt, dispatch_cnt;
`endif

  dispatch_unit dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_op                  (in_op),
    .in_dest                (in_dest),
    .in_src1                (in_src1),
    .in_src2                (in_src2),
    .in_src1_used           (in_src1_used),
    .in_src2_used           (in_src2_used),
    .in_imm                 (in_imm),
    .busy_rd1_addr          (busy_rd1_addr),
    .busy_rd2_addr          (busy_rd2_addr),
    .busy_rd1_data          (busy_rd1_data),
    .busy_rd2_data          (busy_rd2_data),
    .busy_set_en            (busy_set_en),
    .busy_set_addr          (busy_set_addr),
    .phy_rf_rd1_addr        (phy_rf_rd1_addr),
    .phy_rf_rd2_addr        (phy_rf_rd2_addr),
    .phy_rf_rd1_data        (phy_rf_rd1_data),
    .phy_rf_rd2_data        (phy_rf_rd2_data),
    .rob_tail_ptr           (rob_tail_ptr),
    .rob_full               (rob_full),
    .rob_incr_tail_ptr      (rob_incr_tail_ptr),
    .res_st_free            (res_st_free),
    .res_st_wr_en           (res_st_wr_en),
    .res_st_wr_addr         (res_st_wr_addr),
    .res_st_wr_rob_addr     (res_st_wr_rob_addr),
    .res_st_wr_dest         (res_st_wr_dest),
    .res_st_wr_op           (res_st_wr_op),
    .res_st_wr_qj           (res_st_wr_qj),
    .res_st_wr_qk           (res_st_wr_qk),
    .res_st_wr_vj           (res_st_wr_vj),
    .res_st_wr_vk           (res_st_wr_vk),
    .res_st_wr_a            (res_st_wr_a),
    .res_st_retire_en       (res_st_retire_en),
    .res_st_retire_rob_addr (res_st_retire_rob_addr),
    .res_st_retire_value    (res_st_retire_value),
`ifdef DISPATCH_STATS_EN
    .stall_rob_cnt          (stall_rob_cnt),
    .stall_rs_cnt           (stall_rs_cnt),
    .dispatch_cnt           (dispatch_cnt),
`endif
    .mispredicted_branch    (mispredicted_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  slot;
    logic        rinc;
    logic [1:0]  rob;
    logic [5:0]  dest;
    logic [13:0] op;
    logic [2:0]  qj;
    logic [2:0]  qk;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] a;
    logic        bse;
    logic [5:0]  bsa;
  } cell_t;

  typedef struct {
    logic [13:0] op;
    logic [5:0]  dest, src1, src2;
    logic        u1, u2;
    logic [31:0] imm;
    logic        b1, b2;
    logic [31:0] rf1, rf2;
    logic        ren;
    logic [1:0]  rtag;
    logic [31:0] rval;
    logic [1:0]  tail;
    logic [3:0]  free;
    logic [1:0]  e_slot;
    logic [2:0]  e_qj, e_qk;
    logic [31:0] e_vj, e_vk;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  cell_t sb_q[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cell_t mk_cell(input logic [1:0] slot, input logic [1:0] rob,
                                    input logic [5:0] dest, input logic [13:0] op,
                                    input logic [2:0] qj, input logic [2:0] qk,
                                    input logic [31:0] vj, input logic [31:0] vk,
                                    input logic [31:0] a);
    cell_t c;
    c.slot = slot; c.rinc = 1'b1; c.rob = rob; c.dest = dest; c.op = op;
    c.qj = qj; c.qk = qk; c.vj = vj; c.vk = vk; c.a = a;
    c.bse = (dest != 6'd0); c.bsa = dest;
    return c;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    cell_t act, exp;
    if (res_st_wr_en) begin
      act.slot = res_st_wr_addr;   act.rinc = rob_incr_tail_ptr;
      act.rob  = res_st_wr_rob_addr; act.dest = res_st_wr_dest;
      act.op   = res_st_wr_op;     act.qj = res_st_wr_qj; act.qk = res_st_wr_qk;
      act.vj   = res_st_wr_vj;     act.vk = res_st_wr_vk; act.a = res_st_wr_a;
      act.bse  = busy_set_en;      act.bsa = busy_set_addr;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dispatch: got wr_en=1 cell %0h expected no write", act);
      end else begin
        exp = sb_q.pop_front();
        check("cell", act, exp);
        $display("dispatch slot=%0d rob=%0d dest=%0d op=%0d qj=%0d qk=%0d vj=%0h vk=%0h",
                 act.slot, act.rob, act.dest, act.op, act.qj, act.qk, act.vj, act.vk);
      end
    end else begin
      check("idle_strobes", {rob_incr_tail_ptr, busy_set_en, busy_set_addr}, '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uop(input logic [13:0] op, input logic [5:0] dest,
                           input logic [5:0] s1, input logic [5:0] s2,
                           input logic u1, input logic u2, input logic [31:0] imm);
    in_valid = 1'b1; in_op = op; in_dest = dest; in_src1 = s1; in_src2 = s2;
    in_src1_used = u1; in_src2_used = u2; in_imm = imm;
  endtask

  task automatic set_env(input logic b1, input logic b2, input logic [31:0] rf1,
                         input logic [31:0] rf2, input logic ren, input logic [1:0] rtag,
                         input logic [31:0] rval, input logic [1:0] tail, input logic [3:0] free);
    busy_rd1_data = b1; busy_rd2_data = b2;
    phy_rf_rd1_data = rf1; phy_rf_rd2_data = rf2;
    res_st_retire_en = ren; res_st_retire_rob_addr = rtag; res_st_retire_value = rval;
    rob_tail_ptr = tail; res_st_free = free;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{14'd1, 6'd4, 6'd1, 6'd2, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'd11, 32'd12,
                1'b0, 2'd0, 32'd0, 2'd0, 4'b1111, 2'd0, 3'd0, 3'd0, 32'd11, 32'd12};
    vecs[1] = '{14'd2, 6'd5, 6'd4, 6'd0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h44, 32'h55,
                1'b0, 2'd0, 32'd0, 2'd1, 4'b1110, 2'd1, 3'd1, 3'd0, 32'd0, 32'd0};
    vecs[2] = '{14'd3, 6'd6, 6'd5, 6'd3, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h66, 32'd33,
                1'b0, 2'd0, 32'd0, 2'd2, 4'b1110, 2'd1, 3'd2, 3'd0, 32'd0, 32'd33};
    vecs[3] = '{14'd4, 6'd7, 6'd5, 6'd6, 1'b1, 1'b0, 32'h400, 1'b1, 1'b1, 32'h0, 32'h77,
                1'b1, 2'd1, 32'd99, 2'd3, 4'b0100, 2'd2, 3'd0, 3'd0, 32'd99, 32'd0};
    vecs[4] = '{14'd5, 6'd0, 6'd6, 6'd7, 1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h12, 32'd77,
                1'b1, 2'd1, 32'h55, 2'd0, 4'b1000, 2'd3, 3'd3, 3'd0, 32'd0, 32'd77};
    vecs[5] = '{14'd6, 6'd4, 6'd1, 6'd0, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'd55, 32'd66,
                1'b0, 2'd0, 32'd0, 2'd1, 4'b0011, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0};
    vecs[6] = '{14'd7, 6'd9, 6'd4, 6'd4, 1'b1, 1'b1, 32'h700, 1'b1, 1'b1, 32'd1, 32'd2,
                1'b1, 2'd1, 32'hdead, 2'd2, 4'b0110, 2'd1, 3'd0, 3'd0, 32'hdead, 32'hdead};

    rst = 1'b1; rob_full = 1'b0; mispredicted_branch = 1'b0;
    in_valid = 1'b0;
    drive_uop(14'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0);
    in_valid = 1'b0;
    set_env(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 2'd0, 4'b1111);
    step(); step();
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wr_en", res_st_wr_en, 1'b0);
    step();
    rst = 1'b0;
    #2;
    check("post_rst_in_ready", in_ready, 1'b1);
    step();

    // ---------------- table-driven single-uop vectors ----------------
    for (int i = 0; i < 7; i++) begin
      drive_uop(vecs[i].op, vecs[i].dest, vecs[i].src1, vecs[i].src2,
                vecs[i].u1, vecs[i].u2, vecs[i].imm);
      set_env(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 2'd0, 4'b1111);
      #2;
      check($sformatf("vec%0d_ready_empty", i), in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      set_env(vecs[i].b1, vecs[i].b2, vecs[i].rf1, vecs[i].rf2, vecs[i].ren,
              vecs[i].rtag, vecs[i].rval, vecs[i].tail, vecs[i].free);
      sb_q.push_back(mk_cell(vecs[i].e_slot, vecs[i].tail, vecs[i].dest, vecs[i].op,
                             vecs[i].e_qj, vecs[i].e_qk, vecs[i].e_vj, vecs[i].e_vk, vecs[i].imm));
      #2;
      check($sformatf("vec%0d_rd_addr", i),
            {busy_rd1_addr, busy_rd2_addr, phy_rf_rd1_addr, phy_rf_rd2_addr},
            {vecs[i].src1, vecs[i].src2, vecs[i].src1, vecs[i].src2});
      check($sformatf("vec%0d_ready_disp", i), in_ready, 1'b1);
      step();
      check($sformatf("vec%0d_drained", i), sb_q.size(), 0);
    end

    // ---------------- ROB full for 3 cycles ----------------
    drive_uop(14'd8, 6'd8, 6'd7, 6'd9, 1'b1, 1'b1, 32'h800);
    set_env(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 2'd3, 4'b1111);
    step();
    // junk uop offered during the stall must not be taken
    drive_uop(14'h3fff, 6'd63, 6'd1, 6'd1, 1'b1, 1'b1, 32'hffff_ffff);
    rob_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_env(1'b1, 1'b1, 32'd0, 32'd0, (c == 1), 2'd3, 32'h1234, 2'd3, 4'b1111);
      #2;
      check($sformatf("robfull_in_ready_c%0d", c), in_ready, 1'b0);
      step();
    end
    rob_full = 1'b0;
    in_valid = 1'b0;
    // busy bit for src1 cleared during the stall: re-lookup must see RF data
    set_env(1'b0, 1'b1, 32'd700, 32'd0, 1'b0, 2'd0, 32'd0, 2'd3, 4'b1111);
    sb_q.push_back(mk_cell(2'd0, 2'd3, 6'd8, 14'd8, 3'd0, 3'd3, 32'd700, 32'd0, 32'h800));
    step();
    check("robfull_drained", sb_q.size(), 0);
`ifdef DISPATCH_STATS_EN
    check("stall_rob_cnt", stall_rob_cnt, 32'd3);
    check("dispatch_cnt_a", dispatch_cnt, 32'd8);
`endif

    // ---------------- no free slot for 2 cycles, then back-to-back ----------------
    drive_uop(14'd9, 6'd10, 6'd0, 6'd0, 1'b1, 1'b0, 32'd5);
    set_env(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 2'd0, 4'b0000);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      check($sformatf("rsfull_in_ready_c%0d", c), in_ready, 1'b0);
      step();
    end
    res_st_free = 4'b0100;
    drive_uop(14'd10, 6'd11, 6'd10, 6'd8, 1'b1, 1'b1, 32'd6);
    sb_q.push_back(mk_cell(2'd2, 2'd0, 6'd10, 14'd9, 3'd0, 3'd0, 32'd0, 32'd0, 32'd5));
    #2;
    check("b2b_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    set_env(1'b1, 1'b1, 32'd0, 32'd0, 1'b1, 2'd3, 32'h3333, 2'd1, 4'b0001);
    sb_q.push_back(mk_cell(2'd0, 2'd1, 6'd11, 14'd10, 3'd1, 3'd0, 32'd0, 32'h3333, 32'd6));
    step();
    check("b2b_drained", sb_q.size(), 0);
`ifdef DISPATCH_STATS_EN
    check("stall_rs_cnt", stall_rs_cnt, 32'd2);
    check("dispatch_cnt_b", dispatch_cnt, 32'd10);
`endif

    // ---------------- mispredicted branch flush ----------------
    drive_uop(14'd11, 6'd12, 6'd0, 6'd0, 1'b0, 1'b0, 32'd7);
    set_env(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 2'd2, 4'b1111);
    step();
    mispredicted_branch = 1'b1;
    drive_uop(14'd12, 6'd13, 6'd0, 6'd0, 1'b0, 1'b0, 32'd77);
    #2;
    check("flush_in_ready", in_ready, 1'b0);
    check("flush_wr_en", res_st_wr_en, 1'b0);
    step();
    mispredicted_branch = 1'b0;
    in_valid = 1'b0;
    #2;
    check("post_flush_in_ready", in_ready, 1'b1);
    step();
    drive_uop(14'd13, 6'd14, 6'd12, 6'd0, 1'b1, 1'b0, 32'd8);
    step();
    in_valid = 1'b0;
    set_env(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 2'd2, 4'b1111);
    // flushed uop never wrote tag[12], so it still holds its reset value 0
    sb_q.push_back(mk_cell(2'd0, 2'd2, 6'd14, 14'd13, 3'd1, 3'd0, 32'd0, 32'd0, 32'd8));
    step();
    check("flush_drained", sb_q.size(), 0);

    // ---------------- reset in the middle of a stall ----------------
    drive_uop(14'd14, 6'd15, 6'd0, 6'd0, 1'b0, 1'b0, 32'd9);
    set_env(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 2'd0, 4'b1111);
    rob_full = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    rob_full = 1'b0;
    #2;
    check("midstall_rst_in_ready", in_ready, 1'b0);
    check("midstall_rst_wr_en", res_st_wr_en, 1'b0);
    step();
    rst = 1'b0;
    #2;
    check("after_rst_in_ready", in_ready, 1'b1);
    step();
    drive_uop(14'd15, 6'd16, 6'd8, 6'd0, 1'b1, 1'b0, 32'd10);
    step();
    in_valid = 1'b0;
    set_env(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 2'd0, 4'b1111);
    // tag[8] was 3 before reset; after reset it must read 0 -> qj = 1
    sb_q.push_back(mk_cell(2'd0, 2'd0, 6'd16, 14'd15, 3'd1, 3'd0, 32'd0, 32'd0, 32'd10));
    step();
    check("rst_drained", sb_q.size(), 0);
`ifdef DISPATCH_STATS_EN
    check("dispatch_cnt_c", dispatch_cnt, 32'd1);
    check("stall_rob_cnt_c", stall_rob_cnt, 32'd0);
`endif

    step();
    check("final_queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
